// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and types for the SD SPI-mode init sequencer
package sd_pkg;

    localparam logic [7:0] CMD0_BYTE   = 8'h40;
    localparam logic [7:0] CMD8_BYTE   = 8'h48;
    localparam logic [7:0] CMD16_BYTE  = 8'h50;
    localparam logic [7:0] CMD55_BYTE  = 8'h77;
    localparam logic [7:0] CMD58_BYTE  = 8'h7A;
    localparam logic [7:0] ACMD41_BYTE = 8'h69;

    // Only CMD0 and CMD8 need a real CRC7 in SPI mode; the rest send a dummy.
    localparam logic [7:0] CRC_CMD0 = 8'h95;
    localparam logic [7:0] CRC_CMD8 = 8'h87;
    localparam logic [7:0] CRC_NONE = 8'hFF;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_READY   = 8'h00;
    localparam logic [7:0] R1_ILLEGAL = 8'h05;

    // HCS bit tells a v2 card the host understands block addressing.
    localparam logic [31:0] ACMD41_HCS_ARG = 32'h4000_0000;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_CMD0   = 3'd1,
        ERR_CMD8   = 3'd2,
        ERR_ACMD41 = 3'd3,
        ERR_CMD58  = 3'd4,
        ERR_CMD16  = 3'd5,
        ERR_CMD55  = 3'd6
    } err_code_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_CMD0,
        ST_CMD8,
        ST_CMD55,
        ST_ACMD41,
        ST_CMD58,
        ST_CMD16,
        ST_DONE,
        ST_ERROR
    } init_state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

    typedef struct packed {
        init_state_e state;
        phase_e      phase;
    } seq_pos_t;

    function automatic logic is_cmd_state(init_state_e s);
        return (s == ST_CMD0) || (s == ST_CMD8) || (s == ST_CMD55) ||
               (s == ST_ACMD41) || (s == ST_CMD58) || (s == ST_CMD16);
    endfunction

    function automatic logic [7:0] cmd_byte_of(init_state_e s);
        case (s)
            ST_CMD0:   return CMD0_BYTE;
            ST_CMD8:   return CMD8_BYTE;
            ST_CMD55:  return CMD55_BYTE;
            ST_ACMD41: return ACMD41_BYTE;
            ST_CMD58:  return CMD58_BYTE;
            ST_CMD16:  return CMD16_BYTE;
            default:   return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/sd_init_ctr.sv
// rtl/sd_init_ctr.sv - loadable saturating down-counter with zero flag
module sd_init_ctr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins over decrement; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sd_init_seq.sv
// rtl/sd_init_seq.sv - SPI-mode SD card initialisation sequencer driving sd_cmd
module sd_init_seq
    import sd_pkg::*;
#(
    parameter int         BLOCK_LEN      = 512,
    parameter int         CMD_RETRIES    = 8,
    parameter int         ACMD41_TRIES   = 1000,
    parameter int         POWERUP_CYCLES = 80,
    parameter logic [7:0] CHECK_PATTERN  = 8'hAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic        sdhc,
    output logic        cs_n,
    output logic        pwrup_clk_en,
    output logic [7:0]  cmd_byte,
    output logic [31:0] cmd_arg,
    output logic [7:0]  cmd_crc,
    output logic        cmd_start,
    input  logic        cmd_done,
    input  logic [7:0]  rsp_r1,
    input  logic [31:0] rsp_data
);

    localparam int RW = $clog2(CMD_RETRIES + 1);
    localparam int AW = $clog2(ACMD41_TRIES + 1);
    localparam int PW = $clog2(POWERUP_CYCLES + 1);

    localparam logic [31:0] CMD8_ARG  = {20'h0, 4'h1, CHECK_PATTERN};
    localparam logic [31:0] CMD16_ARG = 32'(BLOCK_LEN);

    seq_pos_t   pos_q, pos_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    err_code_e  err_code_q, err_code_d;
    logic       sdhc_q, sdhc_d;
    logic       v2_q, v2_d;
    logic [PW-1:0] pw_q, pw_d;

    logic ret_load, ret_dec, ret_zero;
    logic acmd_load, acmd_dec, acmd_zero;

    // Retry budget for the current command; counters hold "attempts left minus one".
    sd_init_ctr #(.WIDTH(RW)) u_retry_ctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ret_load),
        .load_val_i (RW'(CMD_RETRIES - 1)),
        .dec_i      (ret_dec),
        .zero_o     (ret_zero)
    );

    // CMD55+ACMD41 pair budget for the whole run; never reloaded by the loop.
    sd_init_ctr #(.WIDTH(AW)) u_acmd_ctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (acmd_load),
        .load_val_i (AW'(ACMD41_TRIES - 1)),
        .dec_i      (acmd_dec),
        .zero_o     (acmd_zero)
    );

    logic        cmd_ok;
    logic        no_retry;
    init_state_e nxt_state;
    err_code_e   fail_code;

    // Next-state logic: start handling, power-up count, and response decisions on cmd_done.
    always_comb begin
        pos_d      = pos_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        sdhc_d     = sdhc_q;
        v2_d       = v2_q;
        pw_d       = pw_q;
        ret_dec    = 1'b0;
        acmd_load  = 1'b0;
        acmd_dec   = 1'b0;
        cmd_ok     = 1'b0;
        no_retry   = 1'b0;
        nxt_state  = pos_q.state;
        fail_code  = ERR_NONE;

        case (pos_q.state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    sdhc_d     = 1'b0;
                    v2_d       = 1'b0;
                    pw_d       = PW'(POWERUP_CYCLES - 1);
                    acmd_load  = 1'b1;
                    pos_d      = '{state: ST_POWERUP, phase: PH_ISSUE};
                end
            end
            ST_POWERUP: begin
                if (pw_q == '0) begin
                    pos_d = '{state: ST_CMD0, phase: PH_ISSUE};
                end else begin
                    pw_d = pw_q - 1'b1;
                end
            end
            default: begin
                if (pos_q.phase == PH_ISSUE) begin
                    pos_d.phase = PH_WAIT;
                end else if (cmd_done) begin
                    case (pos_q.state)
                        ST_CMD0: begin
                            fail_code = ERR_CMD0;
                            nxt_state = ST_CMD8;
                            cmd_ok    = (rsp_r1 == R1_IDLE);
                        end
                        ST_CMD8: begin
                            fail_code = ERR_CMD8;
                            nxt_state = ST_CMD55;
                            if (rsp_r1 == R1_IDLE && rsp_data[11:0] == {4'h1, CHECK_PATTERN}) begin
                                cmd_ok = 1'b1;
                                v2_d   = 1'b1;
                            end else if (rsp_r1 == R1_ILLEGAL) begin
                                cmd_ok = 1'b1;
                                v2_d   = 1'b0;
                            end
                        end
                        ST_CMD55: begin
                            fail_code = ERR_CMD55;
                            nxt_state = ST_ACMD41;
                            cmd_ok    = (rsp_r1 == R1_READY) || (rsp_r1 == R1_IDLE);
                        end
                        ST_ACMD41: begin
                            fail_code = ERR_ACMD41;
                            no_retry  = 1'b1;
                            if (rsp_r1 == R1_READY) begin
                                cmd_ok    = 1'b1;
                                nxt_state = v2_q ? ST_CMD58 : ST_CMD16;
                            end else if (rsp_r1 == R1_IDLE && !acmd_zero) begin
                                cmd_ok    = 1'b1;
                                acmd_dec  = 1'b1;
                                nxt_state = ST_CMD55;
                            end
                        end
                        ST_CMD58: begin
                            fail_code = ERR_CMD58;
                            if (rsp_r1 == R1_READY) begin
                                cmd_ok    = 1'b1;
                                sdhc_d    = rsp_data[30];
                                nxt_state = rsp_data[30] ? ST_DONE : ST_CMD16;
                            end
                        end
                        ST_CMD16: begin
                            fail_code = ERR_CMD16;
                            nxt_state = ST_DONE;
                            cmd_ok    = (rsp_r1 == R1_READY);
                        end
                        default: begin
                            fail_code = ERR_NONE;
                        end
                    endcase

                    if (cmd_ok) begin
                        pos_d  = '{state: nxt_state, phase: PH_ISSUE};
                        done_d = (nxt_state == ST_DONE);
                    end else if (!no_retry && !ret_zero) begin
                        ret_dec     = 1'b1;
                        pos_d.phase = PH_ISSUE;
                    end else begin
                        pos_d      = '{state: ST_ERROR, phase: PH_ISSUE};
                        error_d    = 1'b1;
                        err_code_d = fail_code;
                    end
                end
            end
        endcase

        ret_load = (pos_d.state != pos_q.state);
    end

    // State, status flags and power-up counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q      <= '{state: ST_IDLE, phase: PH_ISSUE};
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            sdhc_q     <= 1'b0;
            v2_q       <= 1'b0;
            pw_q       <= '0;
        end else begin
            pos_q      <= pos_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            sdhc_q     <= sdhc_d;
            v2_q       <= v2_d;
            pw_q       <= pw_d;
        end
    end

    // Command bus decode: fields stay stable across ISSUE and WAIT of a command.
    always_comb begin
        cs_n         = 1'b1;
        pwrup_clk_en = 1'b0;
        cmd_start    = 1'b0;
        cmd_byte     = 8'h00;
        cmd_arg      = 32'h0;
        cmd_crc      = 8'h00;
        if (pos_q.state == ST_POWERUP) begin
            pwrup_clk_en = 1'b1;
        end
        if (is_cmd_state(pos_q.state)) begin
            cs_n      = 1'b0;
            cmd_start = (pos_q.phase == PH_ISSUE);
            cmd_byte  = cmd_byte_of(pos_q.state);
            cmd_crc   = CRC_NONE;
            case (pos_q.state)
                ST_CMD0:   cmd_crc = CRC_CMD0;
                ST_CMD8: begin
                    cmd_arg = CMD8_ARG;
                    cmd_crc = CRC_CMD8;
                end
                ST_ACMD41: cmd_arg = v2_q ? ACMD41_HCS_ARG : 32'h0;
                ST_CMD16:  cmd_arg = CMD16_ARG;
                default:   cmd_arg = 32'h0;
            endcase
        end
    end

    logic unused_rsp_bits;
    assign unused_rsp_bits = ^{rsp_data[31], rsp_data[29:12]};

    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign sdhc     = sdhc_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// tb/tb_sd_init_seq.sv - directed self-checking bench for sd_init_seq
module tb_sd_init_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        done, error, sdhc, cs_n, pwrup_clk_en, cmd_start;
    logic [2:0]  err_code;
    logic [7:0]  cmd_byte, cmd_crc;
    logic [31:0] cmd_arg;
    logic        cmd_done = 1'b0;
    logic [7:0]  rsp_r1 = 8'h00;
    logic [31:0] rsp_data = 32'h0;

    always #5 clk = ~clk;

    sd_init_seq #(.ACMD41_TRIES(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .sdhc         (sdhc),
        .cs_n         (cs_n),
        .pwrup_clk_en (pwrup_clk_en),
        .cmd_byte     (cmd_byte),
        .cmd_arg      (cmd_arg),
        .cmd_crc      (cmd_crc),
        .cmd_start    (cmd_start),
        .cmd_done     (cmd_done),
        .rsp_r1       (rsp_r1),
        .rsp_data     (rsp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          scn = 0;
    int          cmd_cnt [256];
    logic [31:0] last_arg [256];
    logic [7:0]  last_crc [256];
    int          acmd_run = 0;
    int          pw_cnt = 0;
    int          pw_at_cmd0 = 0;
    int          cs_bad = 0;

    always @(negedge clk) begin
        if (pwrup_clk_en) begin
            pw_cnt++;
            if (cs_n !== 1'b1) cs_bad++;
        end
    end

    // Behavioural sd_cmd: answers each cmd_start three cycles later.
    initial begin
        for (int i = 0; i < 256; i++) begin
            cmd_cnt[i]  = 0;
            last_arg[i] = 32'h0;
            last_crc[i] = 8'h0;
        end
        forever begin
            @(posedge clk); #1;
            while (cmd_start === 1'b1) begin
                automatic logic [7:0]  b = cmd_byte;
                automatic logic [7:0]  r = 8'hFF;
                automatic logic [31:0] d = 32'h0;
                cmd_cnt[b]++;
                last_arg[b] = cmd_arg;
                last_crc[b] = cmd_crc;
                if (b == 8'h40) begin
                    acmd_run   = 0;
                    pw_at_cmd0 = pw_cnt;
                end
                if (b == 8'h69) acmd_run++;
                case (b)
                    8'h40: r = (scn == 3) ? 8'hFF : 8'h01;
                    8'h48: begin
                        if (scn == 2) r = 8'h05;
                        else begin
                            r = 8'h01;
                            d = (scn == 6) ? 32'h0000_01AB : 32'h0000_01AA;
                        end
                    end
                    8'h77: r = 8'h01;
                    8'h69: begin
                        if (scn == 4) r = 8'h01;
                        else if (scn == 1 || scn == 5) r = (acmd_run < 3) ? 8'h01 : 8'h00;
                        else r = 8'h00;
                    end
                    8'h7A: begin
                        r = 8'h00;
                        d = 32'hC0FF_8000;
                    end
                    8'h50: r = 8'h00;
                    default: r = 8'hFF;
                endcase
                repeat (2) @(posedge clk);
                #1;
                rsp_r1   = r;
                rsp_data = d;
                cmd_done = 1'b1;
                @(posedge clk); #1;
                cmd_done = 1'b0;
            end
        end
    end

    int base [256];
    int pw_base;

    task automatic pulse_start();
        @(negedge clk);
        base    = cmd_cnt;
        pw_base = pw_cnt;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        automatic bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'h0, ok}, 32'h1);
    endtask

    function automatic int ncmd(input logic [7:0] b);
        return cmd_cnt[b] - base[b];
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_err_code", {29'h0, err_code}, 32'h0);
        check("rst_sdhc", {31'h0, sdhc}, 32'h0);
        check("rst_cs_n", {31'h0, cs_n}, 32'h1);
        check("rst_pwrup", {31'h0, pwrup_clk_en}, 32'h0);
        check("rst_cmd_start", {31'h0, cmd_start}, 32'h0);
        check("rst_cmd_fields", {cmd_byte, cmd_crc, 16'h0}, 32'h0);
        check("rst_cmd_arg", cmd_arg, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // SDHC v2 card
        scn = 1;
        pulse_start();
        wait_end("sdhc_end");
        check("sdhc_pwrup_cycles", pw_cnt - pw_base, 80);
        check("sdhc_pwrup_before_cmd0", pw_at_cmd0 - pw_base, 80);
        check("sdhc_cs_during_pwrup", cs_bad, 0);
        check("sdhc_done", {31'h0, done}, 32'h1);
        check("sdhc_error", {31'h0, error}, 32'h0);
        check("sdhc_flag", {31'h0, sdhc}, 32'h1);
        check("sdhc_cmd16_count", ncmd(8'h50), 0);
        check("sdhc_acmd41_count", ncmd(8'h69), 3);
        check("sdhc_cmd55_count", ncmd(8'h77), 3);
        check("sdhc_cmd58_count", ncmd(8'h7A), 1);
        check("sdhc_acmd41_arg", last_arg[8'h69], 32'h4000_0000);
        check("sdhc_cmd8_arg", last_arg[8'h48], 32'h0000_01AA);
        check("sdhc_cmd8_crc", {24'h0, last_crc[8'h48]}, 32'h87);
        check("sdhc_cmd0_crc", {24'h0, last_crc[8'h40]}, 32'h95);
        check("sdhc_cs_n_after", {31'h0, cs_n}, 32'h1);

        // SDSC v1 card
        scn = 2;
        pulse_start();
        wait_end("v1_end");
        check("v1_acmd41_arg", last_arg[8'h69], 32'h0);
        check("v1_cmd58_count", ncmd(8'h7A), 0);
        check("v1_cmd16_count", ncmd(8'h50), 1);
        check("v1_cmd16_arg", last_arg[8'h50], 32'h0000_0200);
        check("v1_done", {31'h0, done}, 32'h1);
        check("v1_sdhc", {31'h0, sdhc}, 32'h0);

        // CMD0 retry limit, then re-run from power-up
        scn = 3;
        pulse_start();
        wait_end("retry_end");
        check("retry_cmd0_count", ncmd(8'h40), 8);
        check("retry_error", {31'h0, error}, 32'h1);
        check("retry_done", {31'h0, done}, 32'h0);
        check("retry_err_code", {29'h0, err_code}, 32'h1);
        repeat (10) @(negedge clk);
        pulse_start();
        check("rerun_pwrup", {31'h0, pwrup_clk_en}, 32'h1);
        check("rerun_error_cleared", {31'h0, error}, 32'h0);
        check("rerun_code_cleared", {29'h0, err_code}, 32'h0);
        wait_end("rerun_end");
        check("rerun_pwrup_cycles", pw_cnt - pw_base, 80);
        check("rerun_err_code", {29'h0, err_code}, 32'h1);

        // ACMD41 timeout with ACMD41_TRIES=3
        scn = 4;
        repeat (10) @(negedge clk);
        pulse_start();
        wait_end("timeout_end");
        check("timeout_cmd55_count", ncmd(8'h77), 3);
        check("timeout_acmd41_count", ncmd(8'h69), 3);
        check("timeout_err_code", {29'h0, err_code}, 32'h3);
        check("timeout_error", {31'h0, error}, 32'h1);

        // CMD8 echo mismatch
        scn = 6;
        repeat (10) @(negedge clk);
        pulse_start();
        wait_end("echo_end");
        check("echo_cmd8_count", ncmd(8'h48), 8);
        check("echo_err_code", {29'h0, err_code}, 32'h2);
        check("echo_cmd55_count", ncmd(8'h77), 0);

        // Reset during CMD8 WAIT
        scn = 5;
        repeat (10) @(negedge clk);
        pulse_start();
        begin
            automatic bit hit = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (ncmd(8'h48) >= 1 && cmd_start == 1'b0 && cs_n == 1'b0) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("rstmid_reach_wait", {31'h0, hit}, 32'h1);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_cs_n", {31'h0, cs_n}, 32'h1);
        check("rstmid_cmd_start", {31'h0, cmd_start}, 32'h0);
        check("rstmid_idle_byte", {24'h0, cmd_byte}, 32'h0);
        check("rstmid_pwrup", {31'h0, pwrup_clk_en}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rstmid_stays_idle", {31'h0, cs_n | done | error}, 32'h1);
        check("rstmid_no_flags", {30'h0, done, error}, 32'h0);

        // start pulsed during ACMD41 is ignored
        scn = 1;
        pulse_start();
        begin
            automatic bit hit = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (cmd_start && cmd_byte == 8'h69) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("busy_reach_acmd41", {31'h0, hit}, 32'h1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_no_pwrup", {31'h0, pwrup_clk_en}, 32'h0);
        wait_end("busy_end");
        check("busy_done", {31'h0, done}, 32'h1);
        check("busy_pwrup_cycles", pw_cnt - pw_base, 80);
        check("busy_cmd0_count", ncmd(8'h40), 1);
        check("busy_acmd41_count", ncmd(8'h69), 3);
        check("busy_sdhc", {31'h0, sdhc}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
